// File: rtl/decoder_pulse_n_if.sv
// Command handshake for decoder_pulse_n: select index, mode and valid/ready.
interface decoder_pulse_n_if #(
  parameter int SEL_W = 3
);
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic             sel_valid;
  logic             sel_ready;

  modport master (
    output mode, sel_in, sel_valid,
    input  sel_ready
  );

  modport slave (
    input  mode, sel_in, sel_valid,
    output sel_ready
  );
endinterface

// File: rtl/decoder_pulse_n.sv
// Registered one-hot decoder with level and timed-pulse output modes.
// Optional macro DECODER_RANGE_ERR_EN: out-of-range selects set sticky err.
module decoder_pulse_n #(
  parameter int SEL_W     = 3,
  parameter int NUM_OUT   = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  decoder_pulse_n_if.slave   cmd,
  output logic [NUM_OUT-1:0] out,
  output logic               busy,
  output logic               err
);
  localparam int CNT_W = $clog2(PULSE_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    PULSE
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_OUT-1:0] out_q;
  logic [NUM_OUT-1:0] dec_d;
  logic               accept;

  always_comb begin
    dec_d = '0;
    for (int i = 0; i < NUM_OUT; i++)
      dec_d[i] = (cmd.sel_in == SEL_W'(i));
  end

  assign cmd.sel_ready = enable && (state_q != PULSE);
  assign accept        = cmd.sel_valid && cmd.sel_ready;
  assign out           = out_q;
  assign busy          = (state_q != IDLE);

`ifdef DECODER_RANGE_ERR_EN
  logic err_q;
  logic in_rng;

  assign in_rng = |dec_d;
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else if (!enable) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else if (state_q == PULSE) begin
      if (cnt_q == '0) begin
        state_q <= IDLE;
        out_q   <= '0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end else if (accept) begin
      // Out-of-range command is consumed but only flags the error
      if (!in_rng) begin
        err_q <= 1'b1;
      end else begin
        out_q <= dec_d;
        if (cmd.mode) begin
          state_q <= PULSE;
          cnt_q   <= CNT_W'(PULSE_LEN - 1);
        end else begin
          state_q <= HOLD;
        end
      end
    end
  end
`else
  assign err = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else if (state_q == PULSE) begin
      if (cnt_q == '0) begin
        state_q <= IDLE;
        out_q   <= '0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end else if (accept) begin
      // Out-of-range select decodes to zero but sequences normally
      out_q <= dec_d;
      if (cmd.mode) begin
        state_q <= PULSE;
        cnt_q   <= CNT_W'(PULSE_LEN - 1);
      end else begin
        state_q <= HOLD;
      end
    end
  end
`endif
endmodule

// File: tb/tb_decoder_pulse_n.sv
// Randomized bench for decoder_pulse_n against a cycle-level reference model.
// Two instances: full decode (8 of 8) and partial decode (6 of 8).
module tb_decoder_pulse_n;
  localparam int SEL_W = 3;
  localparam int PL    = 4;
  localparam int N0    = 8;
  localparam int N1    = 6;

  logic clk = 1'b0;
  logic rst;
  logic enable;

  always #5 clk = ~clk;

  decoder_pulse_n_if #(.SEL_W(SEL_W)) if0 ();
  decoder_pulse_n_if #(.SEL_W(SEL_W)) if1 ();

  logic [N0-1:0] out0;
  logic [N1-1:0] out1;
  logic          busy0, busy1, err0, err1;

  decoder_pulse_n #(
    .SEL_W(SEL_W), .NUM_OUT(N0), .PULSE_LEN(PL)
  ) u0 (
    .clk(clk), .rst(rst), .enable(enable), .cmd(if0.slave),
    .out(out0), .busy(busy0), .err(err0)
  );

  decoder_pulse_n #(
    .SEL_W(SEL_W), .NUM_OUT(N1), .PULSE_LEN(PL)
  ) u1 (
    .clk(clk), .rst(rst), .enable(enable), .cmd(if1.slave),
    .out(out1), .busy(busy1), .err(err1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 idle, 1 holding a level, 2 pulsing
  int m_phase [2];
  int m_left  [2];
  int m_out   [2];
  int m_err   [2];
  int m_num   [2];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit e,
                            input bit v, input bit md, input int s);
    bit ready;
    bit inr;
    ready = e && (m_phase[k] != 2);
    inr   = (s < m_num[k]);
    if (r) begin
      m_phase[k] = 0; m_left[k] = 0; m_out[k] = 0; m_err[k] = 0;
    end else if (!e) begin
      m_phase[k] = 0; m_left[k] = 0; m_out[k] = 0;
    end else if (m_phase[k] == 2) begin
      m_left[k] = m_left[k] - 1;
      if (m_left[k] == 0) begin
        m_phase[k] = 0;
        m_out[k]   = 0;
      end
    end else if (v && ready) begin
`ifdef DECODER_RANGE_ERR_EN
      if (!inr) begin
        m_err[k] = 1;
      end else begin
        m_out[k]   = 2 ** s;
        m_phase[k] = md ? 2 : 1;
        m_left[k]  = PL;
      end
`else
      m_out[k]   = inr ? 2 ** s : 0;
      m_phase[k] = md ? 2 : 1;
      m_left[k]  = PL;
`endif
    end
  endtask

  // One cycle: drive at negedge, check state from the previous edge,
  // then advance the model for the coming edge.
  task automatic cyc(input bit r, input bit e, input bit v,
                     input bit md, input int s);
    int got_out, got_busy, got_err, got_rdy;
    @(negedge clk);
    rst           = r;
    enable        = e;
    if0.sel_valid = v;
    if0.mode      = md;
    if0.sel_in    = SEL_W'(s);
    if1.sel_valid = v;
    if1.mode      = md;
    if1.sel_in    = SEL_W'(s);
    #1;
    for (int k = 0; k < 2; k++) begin
      got_out  = (k == 0) ? int'(out0) : int'(out1);
      got_busy = (k == 0) ? int'(busy0) : int'(busy1);
      got_err  = (k == 0) ? int'(err0) : int'(err1);
      got_rdy  = (k == 0) ? int'(if0.sel_ready) : int'(if1.sel_ready);
      check($sformatf("out%0d", k), got_out, m_out[k]);
      check($sformatf("busy%0d", k), got_busy, int'(m_phase[k] != 0));
      check($sformatf("err%0d", k), got_err, m_err[k]);
      check($sformatf("ready%0d", k), got_rdy,
            int'(e && (m_phase[k] != 2)));
    end
    for (int k = 0; k < 2; k++)
      model_step(k, r, e, v, md, s);
  endtask

  initial begin
    m_num[0] = N0;
    m_num[1] = N1;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_left[k] = 0; m_out[k] = 0; m_err[k] = 0;
    end
    rst           = 1'b1;
    enable        = 1'b1;
    if0.sel_valid = 1'b1;
    if0.mode      = 1'b0;
    if0.sel_in    = '0;
    if1.sel_valid = 1'b1;
    if1.mode      = 1'b0;
    if1.sel_in    = '0;
    @(posedge clk);

    // reset held with a command offered
    cyc(1, 1, 1, 0, 3);
    cyc(1, 1, 1, 1, 5);

    // level sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, i);
      if (i > 0)
        check("sweep", int'(out0), 1 << (i - 1));
    end
    cyc(0, 1, 0, 0, 0);
    check("sweep_last", int'(out0), 8'h80);

    // pulse on sel 5, then an immediate second pulse
    cyc(0, 1, 1, 1, 5);
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 1, 1, 3);
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 0, 0, 0);

    // enable abort mid-pulse on sel 2
    cyc(0, 1, 1, 1, 2);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 4);
    cyc(0, 0, 1, 0, 4);
    cyc(0, 1, 0, 0, 0);

    // out of range from a held level, then pulse mode
    cyc(0, 1, 1, 0, 2);
    cyc(0, 1, 1, 0, 7);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 7);
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1),
          int'($urandom_range(0, 7)));
    end
    cyc(0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decoder_pulse_n.md
# decoder_pulse_n

Parametrised, registered one-hot decoder with a valid/ready command interface and two output modes: level (hold until replaced) and timed pulse (high for exactly PULSE_LEN cycles). It generalises the combinational 3-to-8 decoder to SEL_W select bits and NUM_OUT lines, and adds enable-gated sequencing. It sits between a command source and strobe or chip-select consumers, where a decoded line must stay glitch-free and be held or pulsed for a known time.

## Interface
- SEL_W, default 3: select width.
- NUM_OUT, default 8: number of output lines; legal range 2 .. 2**SEL_W.
- PULSE_LEN, default 4: pulse-mode high time in cycles; must be >= 1.
- CNT_W, derived: $clog2(PULSE_LEN)+1; not overridden by users.
- clk  in  1  the only clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  master enable; low clears outputs and blocks commands.
- mode  in  1  0 = level, 1 = pulse; sampled only on command acceptance.
- sel_in  in  SEL_W  line index to assert.
- sel_valid  in  1  command present.
- sel_ready  out  1  block can accept a command.
- out  out  NUM_OUT  registered one-hot output; all-zero when idle.
- busy  out  1  high when the state is not IDLE.
- err  out  1  sticky out-of-range flag.

## Operation
- The FSM has three states: IDLE, HOLD, PULSE. A down-counter cnt is CNT_W bits wide.
- sel_ready = enable && (state != PULSE). It is combinational and does not depend on sel_valid.
- A command is accepted on any edge where sel_valid && sel_ready.
- On acceptance of an in-range command:
  - out <= 1 << sel_in.
  - If mode=0: next state is HOLD.
  - If mode=1: next state is PULSE and cnt <= PULSE_LEN-1.
- IDLE: out = 0. An accepted command moves the FSM to HOLD or PULSE as above.
- HOLD: out is held.
  - An accepted command replaces out with no zero gap, and moves to HOLD or PULSE according to its mode.
  - Re-issuing the same sel leaves out unchanged.
- PULSE: no command is accepted.
  - While cnt != 0, cnt decrements each cycle.
  - On the edge where cnt == 0: out <= 0 and the FSM returns to IDLE.
- enable low: on the next edge, out <= 0, state <= IDLE and cnt <= 0, from any state. This includes mid-pulse. A pending sel_valid is ignored.
- busy = (state != IDLE).
- Simultaneous events, in priority order: rst, then enable low, then pulse expiry, then command acceptance.

## Timing
- Reset values: out = 0, busy = 0, err = 0, state IDLE, cnt = 0. During and after reset, sel_ready = enable.
- rst dominates all other inputs on the same edge.
- Latency: out changes on the first edge after acceptance (1 cycle).
- Pulse width: out is high for exactly PULSE_LEN consecutive cycles.
- sel_ready returns high in the first cycle with out = 0. Back-to-back pulses therefore have a minimum 1-cycle zero gap.
- Level-to-level replacement has 0 gap cycles.
- Asserting rst mid-pulse truncates the pulse; out = 0 on the next edge.

## Configuration
- Macro: DECODER_RANGE_ERR_EN.
- Defined: when NUM_OUT < 2**SEL_W, an accepted command with sel_in >= NUM_OUT is consumed (the handshake completes) but otherwise ignored.
  - err <= 1 on the next edge.
  - State, out and cnt are unchanged.
  - err clears only on rst.
- Undefined: err is tied to 0. An out-of-range command is accepted normally.
  - out decodes to all-zero.
  - State and counter transitions occur exactly as for an in-range command. For example, in pulse mode busy stays high for PULSE_LEN cycles with out = 0.

## Test plan
- Reset: hold rst for 2 cycles with enable=1 and sel_valid=1 -> out=0, busy=0, err=0, sel_ready=1 throughout.
- Level sweep (SEL_W=3, NUM_OUT=8): send mode=0 commands with sel 0..7 back-to-back -> out=8'h01,02,04,...,80, each 1 cycle after acceptance, with no zero cycles between them; busy=1 throughout.
- Pulse (PULSE_LEN=4): accept mode=1, sel=5 -> out=8'h20 for exactly 4 cycles and sel_ready=0 during them; then out=0, busy=0, and sel_ready=1 in that same cycle. A second pulse issued immediately shows a 1-cycle zero gap.
- Enable abort: during a pulse on sel=2, drop enable at the 2nd high cycle -> out=0 and busy=0 on the next edge. An offered command is not accepted while enable=0.
- Out of range (NUM_OUT=6, macro defined): from HOLD with out=6'h04, send sel=7 -> handshake completes, err=1 next cycle, out stays 6'h04; err stays 1 until rst.
- Out of range, macro undefined: same stimulus with mode=1 -> err=0, out=0, busy=1 for 4 cycles.
